// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand-stage FSM encoding and the hard-wired zero register index.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } stage_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/operand_bypass.sv
// Per-operand source select: x0 reads as zero, a matching writeback wins over register-file data.
module operand_bypass
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [4:0]           rs,
    input  logic [WORD_SIZE-1:0] rf_data,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    output logic [WORD_SIZE-1:0] operand
);

    // The zero test comes first, so a write aimed at x0 can never leak through.
    always_comb begin
        if (rs == REG_ZERO) begin
            operand = '0;
        end else if (wb_valid && (wb_addr == rs)) begin
            operand = wb_data;
        end else begin
            operand = rf_data;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Operand fetch stage: captures a decoded instruction, reads the register file with
// writeback bypass, and presents operands to execute over a valid/ready handshake.
//
// state | meaning
// IDLE  | empty, ready for a new instruction
// READ  | register-file data arriving, operands resolved and registered this cycle
// HOLD  | operands presented to execute, waiting for out_ready
module operand_stage
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int CTRL_W    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [4:0]           in_rd,
    input  logic [WORD_SIZE-1:0] in_imm,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic [4:0]           rf_read_addr1,
    output logic [4:0]           rf_read_addr2,
    input  logic [WORD_SIZE-1:0] rf_read_data1,
    input  logic [WORD_SIZE-1:0] rf_read_data2,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_rs1_data,
    output logic [WORD_SIZE-1:0] out_rs2_data,
    output logic [4:0]           out_rd,
    output logic [WORD_SIZE-1:0] out_imm,
    output logic [CTRL_W-1:0]    out_ctrl
);

    stage_state_t state_q, state_d;

    logic                 accept;
    logic                 capture;
    logic                 load_ops;
    logic [4:0]           rs1_q, rs2_q, rd_q;
    logic [WORD_SIZE-1:0] imm_q;
    logic [CTRL_W-1:0]    ctrl_q;
    logic [WORD_SIZE-1:0] op1_q, op2_q;
    logic [WORD_SIZE-1:0] src1, src2;
    logic [WORD_SIZE-1:0] byp1, byp2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = READ;
                READ:    state_d = HOLD;
                HOLD:    if (out_ready) state_d = accept ? READ : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A flush cycle leaves in_ready untouched but blocks the capture.
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        out_valid = (state_q == HOLD);
        accept    = in_valid && in_ready;
        capture   = accept && !flush;
        load_ops  = !flush && ((state_q == READ) || ((state_q == HOLD) && !out_ready));
    end

    assign rf_read_addr1 = accept ? in_rs1 : rs1_q;
    assign rf_read_addr2 = accept ? in_rs2 : rs2_q;

    // While stalled in HOLD the held operand is fed back through the bypass,
    // so a late writeback to the same register refreshes it.
    assign src1 = (state_q == READ) ? rf_read_data1 : op1_q;
    assign src2 = (state_q == READ) ? rf_read_data2 : op2_q;

    operand_bypass #(.WORD_SIZE(WORD_SIZE)) u_bypass1 (
        .rs       (rs1_q),
        .rf_data  (src1),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .operand  (byp1)
    );

    operand_bypass #(.WORD_SIZE(WORD_SIZE)) u_bypass2 (
        .rs       (rs2_q),
        .rf_data  (src2),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .operand  (byp2)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            imm_q  <= '0;
            ctrl_q <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
        end else begin
            if (capture) begin
                rs1_q  <= in_rs1;
                rs2_q  <= in_rs2;
                rd_q   <= in_rd;
                imm_q  <= in_imm;
                ctrl_q <= in_ctrl;
            end
            if (load_ops) begin
                op1_q <= byp1;
                op2_q <= byp2;
            end
        end
    end

    assign out_rs1_data = op1_q;
    assign out_rs2_data = op2_q;
    assign out_rd       = rd_q;
    assign out_imm      = imm_q;
    assign out_ctrl     = ctrl_q;

endmodule
